// File: rtl/uart_output_if.sv
// uart_output_if: control, memory read port and serial pin of uart_output.
// master drives start/totalSize/read data; slave is the transmitter.
interface uart_output_if #(
   parameter int LineSize = 4
);
   logic                    start;
   logic [31:0]             totalSize;
   logic                    memoryReadEnable;
   logic [31:0]             memoryReadAddr;
   logic [LineSize*8-1:0]   memoryReadValue;
   logic                    uartTx;
   logic                    busy;
   logic                    done;
   logic [31:0]             sentSize;

   modport master (
      output start, totalSize, memoryReadValue,
      input  memoryReadEnable, memoryReadAddr,
      input  uartTx, busy, done, sentSize
   );

   modport slave (
      input  start, totalSize, memoryReadValue,
      output memoryReadEnable, memoryReadAddr,
      output uartTx, busy, done, sentSize
   );
endinterface

// File: rtl/uart_output.sv
// uart_output: streams memory lines out of a UART pin, 8N1, LSB first.
// Define UART_OUTPUT_PARITY_EN to insert an even-parity bit (8E1).
module uart_output #(
   parameter int BaudRate       = 115200,
   parameter int ClockFrequency = 50000000,
   parameter int LineSize       = 4
) (
   input logic          clk,
   input logic          rst,
   uart_output_if.slave bus
);
   localparam int CyclesPerBit = ClockFrequency / BaudRate;
   localparam int CntW  = $clog2(CyclesPerBit + 1);
   localparam int IdxW  = (LineSize > 1) ? $clog2(LineSize) : 1;
   localparam int LineW = LineSize * 8;

   typedef enum logic [2:0] {
      IDLE, READ, WAIT, START, DATA,
`ifdef UART_OUTPUT_PARITY_EN
      PARITY,
`endif
      STOP, FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       sent_q, sent_d;
   logic [31:0]       total_q, total_d;
   logic [LineW-1:0]  line_q, line_d;
   logic [7:0]        shift_q, shift_d;
`ifdef UART_OUTPUT_PARITY_EN
   logic              par_q, par_d;
`endif
   logic              bit_end;
   logic              tx;

   assign bit_end = (cnt_q == CntW'(CyclesPerBit - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      bit_d   = bit_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      sent_d  = sent_q;
      total_d = total_q;
      line_d  = line_q;
      shift_d = shift_q;
`ifdef UART_OUTPUT_PARITY_EN
      par_d   = par_q;
`endif
      tx      = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               total_d = bus.totalSize;
               sent_d  = '0;
               addr_d  = '0;
               state_d = (bus.totalSize == 32'd0) ? FINISH : READ;
            end
         end
         READ: state_d = WAIT;
         WAIT: begin
            line_d  = bus.memoryReadValue;
            idx_d   = '0;
            state_d = START;
         end
         START: begin
            tx    = 1'b0;
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
            if (bit_end) begin
               shift_d = 8'(line_q >> {idx_q, 3'b000});
               bit_d   = '0;
`ifdef UART_OUTPUT_PARITY_EN
               par_d   = ^shift_d;
`endif
               state_d = DATA;
            end
         end
         DATA: begin
            tx    = shift_q[0];
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
            if (bit_end) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_OUTPUT_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_OUTPUT_PARITY_EN
         PARITY: begin
            tx    = par_q;
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
            if (bit_end) state_d = STOP;
         end
`endif
         STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
            if (bit_end) begin
               sent_d = sent_q + 32'd1;
               // a short last line ends here, its tail bytes stay unsent
               if (sent_d == total_q) begin
                  state_d = FINISH;
               end else if (idx_q == IdxW'(LineSize - 1)) begin
                  addr_d  = addr_q + 32'(LineSize);
                  state_d = READ;
               end else begin
                  idx_d   = idx_q + IdxW'(1);
                  state_d = START;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         sent_q  <= '0;
         total_q <= '0;
         line_q  <= '0;
         shift_q <= '0;
`ifdef UART_OUTPUT_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         sent_q  <= sent_d;
         total_q <= total_d;
         line_q  <= line_d;
         shift_q <= shift_d;
`ifdef UART_OUTPUT_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.memoryReadEnable = (state_q == READ);
   assign bus.memoryReadAddr   = addr_q;
   assign bus.uartTx           = tx;
   assign bus.busy             = (state_q != IDLE);
   assign bus.done             = (state_q == FINISH);
   assign bus.sentSize         = sent_q;
endmodule

// File: doc/uart_output.md
# uart_output

UART transmitter paired with the UART input block: it reads a memory image one line at a time and serializes it byte by byte onto a single TX pin (8N1, LSB first). It is used to dump memory contents, such as test results or signatures, from the FPGA board back to a host. It sits between a simple single-cycle-latency memory read port and a GPIO pin.

## Interface
Parameters:
- BaudRate, 115200, serial bit rate.
- ClockFrequency, 50000000, clk frequency in Hz.
- LineSize, 4, memory line width in bytes (≥1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a transfer; sampled only in IDLE.
- totalSize  in  32 (int32_t, unsigned use)  number of bytes to send, latched on accepted start.
- memoryReadEnable  out  1  one-cycle memory read strobe.
- memoryReadAddr  out  32  byte address of the line, always a multiple of LineSize.
- memoryReadValue  in  LineSize*8  line data, valid exactly 1 cycle after memoryReadEnable.
- uartTx  out  1  serial output, high when idle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transfer completes.
- sentSize  out  32  bytes fully transmitted in the current or last transfer.

## Operation
- CyclesPerBit = ClockFrequency / BaudRate, using integer truncation (434 at the defaults). Every bit, including start, data, optional parity and stop, is held for exactly CyclesPerBit cycles.
- States are IDLE, READ, WAIT, START, DATA, PARITY (macro only), STOP and FINISH.
- IDLE: when start=1, latch totalSize, clear sentSize and set the address to 0.
  - If totalSize=0, go to FINISH.
  - Otherwise go to READ.
- READ: assert memoryReadEnable for one cycle with the current address, then go to WAIT.
- WAIT: capture memoryReadValue into the line buffer, set byteIndex to 0, then go to START.
- START: drive uartTx=0, load byte[byteIndex] = bits [8*byteIndex+7 : 8*byteIndex], then go to DATA.
- DATA: shift out 8 bits, LSB first, then go to PARITY (with the macro) or STOP.
- STOP: drive uartTx=1. At the end of the bit, increment sentSize, then choose the next state:
  - if sentSize equals totalSize, go to FINISH;
  - else if byteIndex is LineSize-1, add LineSize to the address and go to READ;
  - otherwise increment byteIndex and go to START.
- FINISH: pulse done for one cycle, then go to IDLE.
- Partial last line: only totalSize mod LineSize bytes of it are sent. The remaining bytes are never transmitted.
- start is ignored while busy=1. totalSize changes after acceptance have no effect.
- sentSize holds its final value in IDLE until the next accepted start.

## Timing
- Reset values: uartTx=1, busy=0, done=0, memoryReadEnable=0, memoryReadAddr=0, sentSize=0, state IDLE.
- Reset mid-frame abandons the transfer. uartTx returns to 1 on the next cycle, and no done pulse is produced.
- Start accepted at cycle T:
  - memoryReadEnable=1 at T+1;
  - data captured at T+2;
  - uartTx falls at T+3.
- Within a line, the next start bit immediately follows the stop bit, with 0 idle cycles.
- Across a line boundary there are exactly 2 idle-high cycles (READ and WAIT) between the stop bit end and the next start bit.
- done is high in the cycle after the last stop bit ends, and busy=0 in the cycle after that.
- totalSize=0: done at T+1, with no read and no uartTx activity.
- Frame length is 10×CyclesPerBit cycles, or 11× with parity.

## Configuration
- UART_OUTPUT_PARITY_EN defined: a PARITY state is inserted after DATA. It sends the even-parity bit (XOR of the 8 data bits) for CyclesPerBit cycles, giving frame format 8E1.
- Undefined: no PARITY state, 8N1 only, and the logic is absent from the netlist.

## Test plan
- Single byte, using ClockFrequency=16 and BaudRate=1 (CyclesPerBit=16): memory[0]=0x000000A5, totalSize=1.
  - Expect uartTx = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then stop bit 1.
  - Expect done 16 cycles after the stop bit starts, and sentSize=1.
- Multi-line with a partial line: totalSize=6, LineSize=4, memory lines 0x44332211 and 0x88776655.
  - Expect bytes 11,22,33,44,55,66 in that order.
  - Expect reads at addresses 0 and 4 only, with a 2-cycle gap at the boundary, and bytes 77 and 88 never sent.
- totalSize=0: expect done at T+1, uartTx constantly 1, no memoryReadEnable.
- start pulsed during transmission with a different totalSize: ignored, and the original byte count completes.
- rst asserted in the middle of DATA: uartTx=1 and busy=0 on the next cycle, no done pulse. A subsequent start works normally from address 0.
- With UART_OUTPUT_PARITY_EN: byte 0x07 gives parity bit 1 and byte 0x03 gives parity bit 0. Frame length is 11×CyclesPerBit.
